// File: rtl/clockworks_gearbox.sv
// clockworks_gearbox: board-clock divider and reset conditioner for the SoC.
//   clk    = CLK / 2^SLOW (SLOW = 0 passes CLK straight through).
//   resetn asserts asynchronously with RESET and releases synchronously to clk.
// Optional macro RESET_STRETCH_EN: adds a hold counter so resetn releases
//   2 + HOLD_CYCLES clk edges after RESET rises; without it the release is
//   2 clk edges after RESET rises and HOLD_CYCLES is ignored.
// Flops without a reset (divider) and the reset-path flops before the first
// RESET assertion rely on the device's power-up/configuration value of zero.
`timescale 1ns/1ps
module clockworks_gearbox #(
    parameter int unsigned SLOW        = 0,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic CLK,
    input  logic RESET,
    output logic clk,
    output logic resetn
);

    // Clock divider: counter keeps running through reset so clk never stops.
    generate
        if (SLOW == 0) begin : g_pass
            assign clk = CLK;
        end else begin : g_div
            logic [SLOW-1:0] div_q;

            // Free-running power-of-two divider; MSB is the 50% duty output clock.
            always_ff @(posedge CLK) begin
                div_q <= div_q + SLOW'(1);
            end

            assign clk = div_q[SLOW-1];
        end
    endgenerate

    // Two-flop reset synchronizer: async assert, release aligned to clk.
    logic sync1_q;
    logic sync2_q;

    // Synchronizer chain, cleared immediately by any low level or glitch on RESET.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= 1'b1;
            sync2_q <= sync1_q;
        end
    end

`ifdef RESET_STRETCH_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              resetn_q;

    // Hold counter next value: count synchronized-release edges, saturate at the target.
    always_comb begin
        hold_d = hold_q;
        if (sync2_q && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    // Hold counter and registered release; compare on next value so resetn rises on the final counting edge.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            hold_q   <= '0;
            resetn_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            resetn_q <= (hold_d == HOLD_MAX);
        end
    end

    assign resetn = resetn_q;
`else
    // Hold length has no effect without the stretch counter.
    logic unused_hold;
    assign unused_hold = (HOLD_CYCLES != 0);

    assign resetn = sync2_q;
`endif

endmodule

// File: tb/tb_clockworks_gearbox.sv
// Directed bench for clockworks_gearbox: three instances (SLOW=0/3/1) sharing one
// board clock, each with its own RESET, checking divider timing and reset release.
`timescale 1ns/1ps
module tb_clockworks_gearbox;

`ifdef RESET_STRETCH_EN
    localparam int LAT16 = 18;
    localparam int LAT1  = 3;
`else
    localparam int LAT16 = 2;
    localparam int LAT1  = 2;
`endif

    logic CLK  = 1'b0;
    logic rst0 = 1'b1;
    logic rst3 = 1'b1;
    logic rst1 = 1'b1;
    logic clk0, clk3, clk1;
    logic rn0, rn3, rn1;

    int n_vec  = 0;
    int n_miss = 0;

    int clk_pos_n = 0;
    int t3_first  = -1;
    int rn0_rises = 0;

    clockworks_gearbox #(.SLOW(0), .HOLD_CYCLES(16)) u_slow0 (
        .CLK(CLK), .RESET(rst0), .clk(clk0), .resetn(rn0)
    );
    clockworks_gearbox #(.SLOW(3), .HOLD_CYCLES(16)) u_slow3 (
        .CLK(CLK), .RESET(rst3), .clk(clk3), .resetn(rn3)
    );
    clockworks_gearbox #(.SLOW(1), .HOLD_CYCLES(1)) u_slow1 (
        .CLK(CLK), .RESET(rst1), .clk(clk1), .resetn(rn1)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) clk_pos_n <= clk_pos_n + 1;

    // Board-clock edge count at the first SLOW=3 clk rising edge.
    always @(posedge clk3) if (t3_first < 0) t3_first = clk_pos_n;

    always @(posedge rn0) rn0_rises = rn0_rises + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic rn_of(input int which);
        case (which)
            0:       return rn0;
            1:       return rn1;
            default: return rn3;
        endcase
    endfunction

    // Count clk rising edges of one instance until its resetn is seen high (-1 on timeout).
    task automatic edges_to_release(input int which, output int n);
        bit done;
        done = 1'b0;
        n    = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            case (which)
                0:       @(posedge clk0);
                1:       @(posedge clk1);
                default: @(posedge clk3);
            endcase
            #1;
            n++;
            if (rn_of(which)) done = 1'b1;
        end
        if (!done) n = -1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a, b, c, base;

        // Power-up: resetn low at time zero even though RESET is high
        #1;
        chk("pwr_rn0", int'(rn0), 0);
        chk("pwr_rn3", int'(rn3), 0);
        chk("pwr_rn1", int'(rn1), 0);

        edges_to_release(0, n);
        chk("pwr_release_slow0", n, LAT16);

        // SLOW=0: clk follows CLK
        @(posedge CLK); #1;
        chk("clk0_high", int'(clk0), 1);
        @(negedge CLK); #1;
        chk("clk0_low", int'(clk0), 0);

        // 1 ns glitch between clk edges
        @(negedge CLK); #2;
        rst0 = 1'b0;
        #1;
        chk("glitch_assert", int'(rn0), 0);
        rst0 = 1'b1;
        edges_to_release(0, n);
        chk("glitch_release", n, LAT16);

        // Reset re-asserted part way through release
        @(negedge CLK); #2;
        rst0 = 1'b0;
        #2;
        rst0 = 1'b1;
        repeat (10) @(posedge clk0);
        #1;
        chk("mid_release_rn", int'(rn0), (LAT16 <= 10) ? 1 : 0);
        @(negedge CLK); #2;
        rst0 = 1'b0;
        #2;
        rst0 = 1'b1;
        edges_to_release(0, n);
        chk("mid_release_restart", n, LAT16);

        // Bouncing RESET: three low/high toggles, none coinciding with a clk edge
        @(posedge CLK); #2;
        base = rn0_rises;
        rst0 = 1'b0; #4;
        rst0 = 1'b1; #5;
        rst0 = 1'b0; #8;
        rst0 = 1'b1; #6;
        rst0 = 1'b0; #9;
        rst0 = 1'b1;
        edges_to_release(0, n);
        chk("bounce_release", n, LAT16);
        chk("bounce_single_rise", rn0_rises - base, 1);

        // SLOW=1, HOLD_CYCLES=1
        chk("slow1_pwr_released", int'(rn1), 1);
        @(negedge clk1); #2;
        rst1 = 1'b0;
        #1;
        chk("slow1_assert", int'(rn1), 0);
        #1;
        rst1 = 1'b1;
        edges_to_release(1, n);
        chk("slow1_release", n, LAT1);
        @(posedge clk1); a = clk_pos_n;
        @(negedge clk1); b = clk_pos_n;
        @(posedge clk1); c = clk_pos_n;
        chk("slow1_high_len", b - a, 1);
        chk("slow1_period", c - a, 2);

        // SLOW=3: first edge, period and duty while held in reset
        chk("slow3_first_edge", t3_first, 4);
        @(negedge clk3); #2;
        rst3 = 1'b0;
        #1;
        chk("slow3_assert", int'(rn3), 0);
        @(posedge clk3); a = clk_pos_n;
        @(negedge clk3); b = clk_pos_n;
        @(posedge clk3); c = clk_pos_n;
        chk("slow3_high_len", b - a, 4);
        chk("slow3_period", c - a, 8);
        #1;
        chk("slow3_held", int'(rn3), 0);
        @(negedge clk3); #2;
        rst3 = 1'b1;
        edges_to_release(3, n);
        chk("slow3_release", n, LAT16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
